// File: rtl/loop_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | loop_pkg                                                                   |
// | Shared definitions for the upstream k/i loop and its capture FIFO:         |
// | loop-phase encodings, default saturation limit, field widths and the       |
// | packed layout of one captured entry.                                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package loop_pkg;

  // Upstream loop phase carried on turn_in
  typedef enum logic [2:0] {
    TURN_START   = 3'd0,
    TURN_INNER   = 3'd1,
    TURN_ADVANCE = 3'd2,
    TURN_DONE    = 3'd3
  } turn_e;

  localparam int K_LIMIT_DEFAULT = 2000;
  localparam int DATA_W          = 11;
  localparam int CNT_W           = 5;
  localparam int ENTRY_W         = 2 * DATA_W;

  // One FIFO entry: outer index in the upper half, accumulator in the lower
  typedef struct packed {
    logic [DATA_W-1:0] i;
    logic [DATA_W-1:0] k;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo                                                                  |
// | Single-clock FIFO storage with occupancy count. Push is accepted when not  |
// | full, or when full and a pop happens in the same cycle. Head data is       |
// | forced to zero while empty so the outputs are clean during reset.         |
// |                                                                            |
// | Ports:                                                                     |
// |   clk      in   clock                                                      |
// |   rst_n    in   asynchronous active-low reset (already release-synced)    |
// |   i_push   in   write request                                              |
// |   i_pop    in   read request (ignored while empty)                         |
// |   i_data   in   WIDTH-bit write payload                                    |
// |   o_valid  out  FIFO holds at least one entry                              |
// |   o_data   out  head entry (zero while empty)                              |
// |   o_count  out  occupancy 0..DEPTH                                         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sync_fifo
  import loop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_valid   = (r_count != '0);
  assign w_pop_ok  = i_pop && o_valid;
  // When full, the slot being written is the one being vacated this edge
  assign w_push_ok = i_push && ((r_count != c_DEPTH) || w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/k_capture_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | k_capture_fifo                                                             |
// | Watches an upstream i/k loop and captures {i,k} at the end of every outer  |
// | iteration (ADVANCE followed by START) into a small FIFO. Tracks sticky     |
// | completion, overflow and monotonic-k error flags.                          |
// |                                                                            |
// | Ports:                                                                     |
// |   clk        in   clock                                                    |
// |   rst        in   asynchronous active-low reset                            |
// |   turn_in    in   upstream loop phase                                      |
// |   k_in       in   upstream accumulator                                     |
// |   i_in       in   upstream outer index                                     |
// |   out_valid  out  FIFO non-empty                                           |
// |   out_ready  in   consumer accept                                          |
// |   out_i      out  head outer index                                         |
// |   out_k      out  head accumulator                                         |
// |   count      out  occupancy 0..DEPTH                                       |
// |   done       out  sticky upstream completion                               |
// |   overflow   out  sticky dropped capture                                   |
// |   mono_err   out  sticky non-increasing k between captures                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module k_capture_fifo
  import loop_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int K_LIMIT = K_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        turn_in,
  input  logic [DATA_W-1:0] k_in,
  input  logic [DATA_W-1:0] i_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_k,
  output logic [CNT_W-1:0]  count,
  output logic              done,
  output logic              overflow,
  output logic              mono_err
);

  localparam logic [DATA_W-1:0] c_K_LIMIT = DATA_W'(K_LIMIT);
  localparam logic [CNT_W-1:0]  c_DEPTH   = CNT_W'(DEPTH);

  // Reset asserts immediately but releases two clock edges later
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [2:0]        r_prev_turn;
  logic              r_done;
  logic              r_overflow;
  logic              r_mono_err;
  logic              r_first_seen;
  logic [DATA_W-1:0] r_last_k;

  logic              w_capture;
  logic              w_done_now;
  logic              w_capture_live;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_mono;
  logic              w_fifo_valid;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [ENTRY_W-1:0] w_fifo_data;
  entry_t            w_push_entry;
  entry_t            w_head;

  assign w_capture  = (r_prev_turn == TURN_ADVANCE) && (turn_in == TURN_START);
  assign w_done_now = (turn_in == TURN_DONE) || (k_in >= c_K_LIMIT);
  // A capture coinciding with the completion cycle is already post-completion
  assign w_capture_live = w_capture && !r_done && !w_done_now;

  assign w_pop  = w_fifo_valid && out_ready;
  assign w_push = w_capture_live && ((w_fifo_count != c_DEPTH) || w_pop);
  assign w_drop = w_capture_live && !w_push;
  assign w_mono = w_push && r_first_seen && (k_in <= r_last_k);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_prev_turn  <= 3'd0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_mono_err   <= 1'b0;
      r_first_seen <= 1'b0;
      r_last_k     <= '0;
    end else begin
      r_prev_turn <= turn_in;
      if (w_done_now) r_done     <= 1'b1;
      if (w_drop)     r_overflow <= 1'b1;
      if (w_mono)     r_mono_err <= 1'b1;
      if (w_push) begin
        r_first_seen <= 1'b1;
        r_last_k     <= k_in;
      end
    end
  end

  assign w_push_entry = '{i: i_in, k: k_in};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count)
  );

  assign w_head    = entry_t'(w_fifo_data);
  assign out_valid = w_fifo_valid;
  assign out_i     = w_head.i;
  assign out_k     = w_head.k;
  assign count     = w_fifo_count;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign mono_err  = r_mono_err;

endmodule
`default_nettype wire

// File: tb/tb_k_capture_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_k_capture_fifo                                                          |
// | Scenario bench for k_capture_fifo: expected entries are queued as captures |
// | are driven and compared as the consumer accepts them.                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_k_capture_fifo;

  logic        clk;
  logic        rst;
  logic [2:0]  turn_in;
  logic [10:0] k_in;
  logic [10:0] i_in;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_i;
  logic [10:0] out_k;
  logic [4:0]  count;
  logic        done;
  logic        overflow;
  logic        mono_err;

  int vectors     = 0;
  int miscompares = 0;
  logic [21:0] sb[$];

  k_capture_fifo #(
    .DEPTH   (4),
    .K_LIMIT (2000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .turn_in   (turn_in),
    .k_in      (k_in),
    .i_in      (i_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i     (out_i),
    .out_k     (out_k),
    .count     (count),
    .done      (done),
    .overflow  (overflow),
    .mono_err  (mono_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: score the entry about to be consumed, then advance to #1 past the edge
  task automatic cycle();
    logic [21:0] exp;
    if (out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_pop got i=%0d k=%0d want no entry", out_i, out_k);
      end else begin
        exp = sb.pop_front();
        if ({out_i, out_k} !== exp) begin
          miscompares++;
          $display("FAIL sb_head got i=%0d k=%0d want i=%0d k=%0d",
                   out_i, out_k, exp[21:11], exp[10:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int t, input int i, input int k);
    turn_in = 3'(t);
    i_in    = 11'(i);
    k_in    = 11'(k);
    cycle();
  endtask

  task automatic cap_pre(input int i, input int k);
    drive(1, i, k);
    drive(2, i, k);
  endtask

  task automatic cap_fire(input int i, input int k, input bit exp_push);
    if (exp_push) sb.push_back({11'(i), 11'(k)});
    drive(0, i, k);
  endtask

  task automatic cap(input int i, input int k, input bit exp_push);
    cap_pre(i, k);
    cap_fire(i, k, exp_push);
  endtask

  task automatic do_reset();
    out_ready = 1'b0;
    turn_in   = 3'd0;
    i_in      = '0;
    k_in      = '0;
    rst       = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int n = 0; n < 3; n++) drive(0, 0, 0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 10 && sb.size() > 0; n++) drive(1, 0, 0);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout got %0d left want 0", sb.size());
    end
    vectors++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty got count=%0d valid=%0b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      miscompares++;
      $display("FAIL rst_occupancy got valid=%0b count=%0d want 0 0", out_valid, count);
    end
    vectors++;
    if ({done, overflow, mono_err} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_flags got %03b want 000", {done, overflow, mono_err});
    end
    vectors++;
    if (out_i !== 11'd0 || out_k !== 11'd0) begin
      miscompares++;
      $display("FAIL rst_data got i=%0d k=%0d want 0 0", out_i, out_k);
    end
  endtask

  task automatic test_upstream();
    do_reset();
    out_ready = 1'b1;
    drive(0, 2, 0);
    drive(1, 2, 2);
    drive(2, 2, 2);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL up_no_bypass got valid=%0b want 0", out_valid);
    end
    cap_fire(2, 2, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_i !== 11'd2 || out_k !== 11'd2) begin
      miscompares++;
      $display("FAIL up_first got v=%0b i=%0d k=%0d want 1 2 2", out_valid, out_i, out_k);
    end
    drive(1, 3, 5);
    drive(2, 3, 5);
    cap_fire(3, 5, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_i !== 11'd3 || out_k !== 11'd5) begin
      miscompares++;
      $display("FAIL up_second got v=%0b i=%0d k=%0d want 1 3 5", out_valid, out_i, out_k);
    end
    drain();
  endtask

  task automatic test_overflow();
    do_reset();
    cap(1, 10, 1'b1);
    cap(2, 20, 1'b1);
    cap(3, 30, 1'b1);
    cap(4, 40, 1'b1);
    cap(5, 50, 1'b0);
    for (int n = 0; n < 3; n++) drive(1, 0, 0);
    vectors++;
    if (count !== 5'd4 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_state got count=%0d ovf=%0b want 4 1", count, overflow);
    end
    vectors++;
    if (out_i !== 11'd1 || out_k !== 11'd10) begin
      miscompares++;
      $display("FAIL ovf_hold got i=%0d k=%0d want 1 10", out_i, out_k);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset();
    cap(1, 10, 1'b1);
    cap(2, 20, 1'b1);
    cap(3, 30, 1'b1);
    cap(4, 40, 1'b1);
    cap_pre(5, 50);
    out_ready = 1'b1;
    cap_fire(5, 50, 1'b1);
    out_ready = 1'b0;
    vectors++;
    if (count !== 5'd4 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full got count=%0d ovf=%0b want 4 0", count, overflow);
    end
    drain();
  endtask

  task automatic test_mono();
    do_reset();
    cap(1, 10, 1'b1);
    vectors++;
    if (mono_err !== 1'b0 || count !== 5'd1) begin
      miscompares++;
      $display("FAIL mono_first got err=%0b count=%0d want 0 1", mono_err, count);
    end
    cap(2, 10, 1'b1);
    vectors++;
    if (mono_err !== 1'b1 || count !== 5'd2) begin
      miscompares++;
      $display("FAIL mono_equal got err=%0b count=%0d want 1 2", mono_err, count);
    end
    drain();
  endtask

  task automatic test_done();
    do_reset();
    out_ready = 1'b1;
    cap(1, 5, 1'b1);
    drive(3, 1, 5);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_turn got %0b want 1", done);
    end
    cap(2, 7, 1'b0);
    vectors++;
    if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL done_ignore got count=%0d v=%0b ovf=%0b want 0 0 0", count, out_valid, overflow);
    end

    do_reset();
    drive(1, 0, 1999);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_below got %0b want 0", done);
    end
    drive(1, 0, 2000);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_klimit got %0b want 1", done);
    end
    cap(1, 5, 1'b0);
    vectors++;
    if (count !== 5'd0) begin
      miscompares++;
      $display("FAIL done_klimit_push got count=%0d want 0", count);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    cap(1, 10, 1'b1);
    cap(2, 20, 1'b1);
    cap(3, 20, 1'b1);
    vectors++;
    if (count !== 5'd3 || mono_err !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_setup got count=%0d err=%0b want 3 1", count, mono_err);
    end
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || count !== 5'd0 || {done, overflow, mono_err} !== 3'b000) begin
      miscompares++;
      $display("FAIL mid_async got v=%0b count=%0d flags=%03b want 0 0 000",
               out_valid, count, {done, overflow, mono_err});
    end
    vectors++;
    if (out_i !== 11'd0 || out_k !== 11'd0) begin
      miscompares++;
      $display("FAIL mid_data got i=%0d k=%0d want 0 0", out_i, out_k);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int n = 0; n < 3; n++) drive(0, 0, 0);
    cap(1, 5, 1'b1);
    vectors++;
    if (mono_err !== 1'b0 || count !== 5'd1) begin
      miscompares++;
      $display("FAIL mid_first got err=%0b count=%0d want 0 1", mono_err, count);
    end
    cap(2, 5, 1'b1);
    vectors++;
    if (mono_err !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_tracking got err=%0b want 1", mono_err);
    end
    drain();
  endtask

  initial begin
    rst       = 1'b0;
    out_ready = 1'b0;
    turn_in   = 3'd0;
    i_in      = '0;
    k_in      = '0;
    @(posedge clk); #1;
    test_reset();
    test_upstream();
    test_overflow();
    test_back_to_back();
    test_mono();
    test_done();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/k_capture_fifo.md
K_CAPTURE_FIFO -- requirements
Module: k_capture_fifo

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of FIFO entries (power of two, 2..16).
REQ-002 Parameter K_LIMIT, default 2000, SHALL set the k value at which the upstream loop is treated as saturated.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 turn_in  input  3  SHALL carry the upstream loop phase (0 = start, 1 = inner, 2 = advance, 3 = finished).
REQ-006 k_in  input  11  SHALL carry the upstream accumulator.
REQ-007 i_in  input  11  SHALL carry the upstream outer index.
REQ-008 out_valid  output  1  SHALL be high whenever the FIFO holds at least one entry.
REQ-009 out_ready  input  1  SHALL be the consumer accept signal.
REQ-010 out_i  output  11  SHALL be the head-entry outer index.
REQ-011 out_k  output  11  SHALL be the head-entry accumulator value.
REQ-012 count  output  5  SHALL be the current occupancy, 0..DEPTH.
REQ-013 done  output  1  SHALL be the sticky flag for upstream completion.
REQ-014 overflow  output  1  SHALL be the sticky flag for a dropped capture.
REQ-015 mono_err  output  1  SHALL be the sticky flag for a non-increasing k between captures.

Function
REQ-016 The block SHALL register turn_in as prev_turn each cycle.
REQ-017 The capture event SHALL be prev_turn==2 and turn_in==0, i.e. end of one outer iteration; in that cycle {i_in, k_in} is the push payload.
REQ-018 Push SHALL be accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-019 When a push is rejected, the payload SHALL be dropped, overflow SHALL set, and FIFO contents SHALL be unchanged.
REQ-020 Pop SHALL occur when out_valid and out_ready are both high; the head SHALL advance on that edge.
REQ-021 Push-to-out_valid latency SHALL be 1 cycle; there is no combinational bypass from an empty FIFO.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; with count==1, the new entry SHALL become head on the next cycle.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-024 out_i/out_k SHALL be held stable while out_valid is high and out_ready is low.
REQ-025 done SHALL set on the first cycle with turn_in==3 or k_in>=K_LIMIT; captures after done SHALL be ignored.
REQ-026 A last_k register SHALL store the k of each accepted push; mono_err SHALL set if a new capture has k_in<=last_k, and the entry SHALL still be pushed.
REQ-027 The first capture after reset SHALL NOT be compared, tracked by a first_seen bit.
REQ-028 Arithmetic SHALL be unsigned 11-bit; the comparison with K_LIMIT SHALL be unsigned.

Reset
REQ-029 On rst low, the block SHALL immediately clear pointers, count, done, overflow, mono_err, first_seen and last_k, and set prev_turn to 0.
REQ-030 During reset, out_valid SHALL be 0 and out_i/out_k SHALL be 0.
REQ-031 Reset asserted mid-stream SHALL discard all entries.
REQ-032 Reset deassertion SHALL be synchronised to clk by a 2-flop release synchroniser.

Structure
REQ-033 The turn encodings (TURN_START/INNER/ADVANCE/DONE) and the default K_LIMIT SHALL live in a shared package, loop_pkg.
REQ-034 Storage SHALL be one sub-module, sync_fifo (parameter DEPTH, WIDTH=22); capture, flag and compare logic SHALL live in k_capture_fifo.

Verification
REQ-035 Upstream run from reset with out_ready=1: the first capture SHALL be {i=2,k=2} and the second {i=3,k=5}, each visible 1 cycle after its 2->0 edge.
REQ-036 out_ready=0 across 5 captures with DEPTH=4: count SHALL reach 4, overflow SHALL equal 1, and the drained order SHALL be the first four captures.
REQ-037 count==4 with out_ready=1 on a capture cycle: the push SHALL be accepted, count SHALL stay 4, and overflow SHALL stay 0.
REQ-038 Forcing k_in=10 at capture after last_k=10: mono_err SHALL equal 1 and count SHALL increment.
REQ-039 Driving turn_in=3, or k_in=2000, then a later 2->0 edge: done SHALL equal 1 and no push SHALL occur.
REQ-040 rst low for 1 cycle with count=3: out_valid, count and all flags SHALL be 0 immediately, and the next capture SHALL skip the monotonic check.
